// File: rtl/aes128_key_scheduler.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry buffer,
// with a registered random-access read port that serves rounds as soon as they exist.

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX[in_byte];
endmodule

module aes128_key_scheduler #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [KW-1:0] key_in,
    input  logic          key_load,
    input  logic          rd_req,
    input  logic [3:0]    rd_idx,
    output logic [KW-1:0] rd_key,
    output logic          rd_valid,
    output logic          rd_miss,
    output logic          busy,
    output logic          key_ready,
    output logic [3:0]    rounds_avail
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    rc;
    logic [KW-1:0] rk [0:NR];

    logic [3:0]    prev_idx;
    logic [KW-1:0] prev_key;
    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   rot_word, sub_word, t;
    logic [31:0]   n0, n1, n2, n3;
    logic [7:0]    rcon;
    logic          expand_en;
    logic          last_round;
    logic          rd_hit;

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    rcon_of = 8'h01;
            4'd2:    rcon_of = 8'h02;
            4'd3:    rcon_of = 8'h04;
            4'd4:    rcon_of = 8'h08;
            4'd5:    rcon_of = 8'h10;
            4'd6:    rcon_of = 8'h20;
            4'd7:    rcon_of = 8'h40;
            4'd8:    rcon_of = 8'h80;
            4'd9:    rcon_of = 8'h1b;
            4'd10:   rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

    // rc is 0 only in IDLE, where the expansion result is unused; clamp to keep the index legal
    assign prev_idx = (rc == 4'd0) ? 4'd0 : rc - 4'd1;
    assign prev_key = rk[prev_idx];
    assign {w0, w1, w2, w3} = prev_key;
    assign rot_word = {w3[23:0], w3[31:24]};
    assign rcon     = rcon_of(rc);

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*i +: 8]),
            .out_byte (sub_word[8*i +: 8])
        );
    end

    assign t  = sub_word ^ {rcon, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign expand_en  = (state == EXPAND) && !key_load;
    assign last_round = (rc == 4'(NR));
    assign busy       = (state == EXPAND);
    assign key_ready  = (state == READY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A load restarts expansion from any state; otherwise EXPAND runs until round NR is written
    always_comb begin
        state_next = state;
        if (key_load) begin
            state_next = EXPAND;
        end else begin
            case (state)
                EXPAND:  if (last_round) state_next = READY;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc           <= 4'd0;
            rounds_avail <= 4'd0;
            for (int i = 0; i <= NR; i++) begin
                rk[i] <= '0;
            end
        end else if (key_load) begin
            rk[0]        <= key_in;
            rc           <= 4'd1;
            rounds_avail <= 4'd1;
        end else if (expand_en) begin
            rk[rc]       <= {n0, n1, n2, n3};
            rounds_avail <= rc + 4'd1;
            if (!last_round) begin
                rc <= rc + 4'd1;
            end
        end
    end

    // Reads compare against the pre-edge count, so the round being written this cycle misses
    assign rd_hit = rd_req && !key_load && (rd_idx < rounds_avail);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_miss  <= 1'b0;
        end else begin
            rd_valid <= rd_hit;
            rd_miss  <= rd_req && !rd_hit;
            if (rd_hit) begin
                rd_key <= rk[rd_idx];
            end
        end
    end
endmodule

// File: tb/tb_aes128_key_scheduler.sv
// Scoreboard bench for aes128_key_scheduler using FIPS-197 and all-zero key vectors.

module tb_aes128_key_scheduler;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_load;
    logic         rd_req;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         rd_miss;
    logic         busy;
    logic         key_ready;
    logic [3:0]   rounds_avail;

    int n_checks = 0;
    int n_pass   = 0;

    bit           exp_valid_q [$];
    logic [127:0] exp_key_q   [$];
    string        exp_name_q  [$];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes128_key_scheduler #(.NR(10), .KW(128)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .key_load     (key_load),
        .rd_req       (rd_req),
        .rd_idx       (rd_idx),
        .rd_key       (rd_key),
        .rd_valid     (rd_valid),
        .rd_miss      (rd_miss),
        .busy         (busy),
        .key_ready    (key_ready),
        .rounds_avail (rounds_avail)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle from a negedge; returns at the next negedge with that edge's outputs visible
    task automatic applyStimulus(input bit load, input logic [127:0] key, input bit req,
                                 input logic [3:0] idx, input bit exp_v,
                                 input logic [127:0] exp_k, input string name);
        key_load = load;
        key_in   = key;
        rd_req   = req;
        rd_idx   = idx;
        if (req) begin
            exp_valid_q.push_back(exp_v);
            exp_key_q.push_back(exp_k);
            exp_name_q.push_back(name);
        end
        @(negedge clk);
        key_load = 1'b0;
        rd_req   = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 4'd0, 1'b0, '0, "idle");
    endtask

    task automatic waitReady(input string name, output int busy_cnt);
        int guard;
        busy_cnt = 0;
        guard    = 0;
        while (!key_ready && guard < 30) begin
            if (busy) busy_cnt++;
            idleCycle();
            guard++;
        end
        checkOutput({name, "_key_ready"}, 128'(key_ready), 128'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && (rd_valid || rd_miss)) begin
            if (exp_valid_q.size() == 0) begin
                checkOutput("unexpected_read_response", {126'd0, rd_valid, rd_miss}, 128'd0);
            end else begin
                bit           ev;
                logic [127:0] ek;
                string        en;
                ev = exp_valid_q.pop_front();
                ek = exp_key_q.pop_front();
                en = exp_name_q.pop_front();
                checkOutput({en, "_status"}, {126'd0, rd_valid, rd_miss}, {126'd0, ev, !ev});
                if (ev) checkOutput({en, "_data"}, rd_key, ek);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bc;
        rst_n    = 1'b0;
        key_load = 1'b0;
        key_in   = '0;
        rd_req   = 1'b0;
        rd_idx   = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_rd_key", rd_key, '0);
        checkOutput("reset_flags", {123'd0, rd_valid, rd_miss, busy, key_ready, 1'b0},
                    128'd0);
        checkOutput("reset_rounds_avail", 128'(rounds_avail), 128'd0);
        rst_n = 1'b1;
        idleCycle();

        // Reads before any key and out-of-range indices
        applyStimulus(1'b0, '0, 1'b1, 4'd0, 1'b0, '0, "pre_load_idx0");
        applyStimulus(1'b0, '0, 1'b1, 4'd11, 1'b0, '0, "pre_load_idx11");

        // FIPS-197 load with a simultaneous read that must lose to the load
        applyStimulus(1'b1, FIPS_KEY, 1'b1, 4'd0, 1'b0, '0, "load_and_read");
        checkOutput("after_load_rounds_avail", 128'(rounds_avail), 128'd1);
        waitReady("fips", bc);
        checkOutput("fips_busy_cycles", 128'(bc), 128'd10);
        checkOutput("fips_rounds_avail", 128'(rounds_avail), 128'd11);
        applyStimulus(1'b0, '0, 1'b1, 4'd1, 1'b1, FIPS_RK[1], "fips_idx1");
        applyStimulus(1'b0, '0, 1'b1, 4'd10, 1'b1, FIPS_RK[10], "fips_idx10");
        applyStimulus(1'b0, '0, 1'b1, 4'd0, 1'b1, FIPS_KEY, "fips_idx0");
        applyStimulus(1'b0, '0, 1'b1, 4'd10, 1'b1, FIPS_RK[10], "fips_idx10_again");
        applyStimulus(1'b0, '0, 1'b1, 4'd15, 1'b0, '0, "ready_idx15");
        checkOutput("miss_holds_rd_key", rd_key, FIPS_RK[10]);
        applyStimulus(1'b0, '0, 1'b1, 4'd11, 1'b0, '0, "ready_idx11");

        // Overlapped reads: round i requested exactly when it first becomes readable
        applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0, 1'b0, '0, "overlap_load");
        for (int i = 0; i <= 10; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 4'(i), 1'b1, FIPS_RK[i], $sformatf("overlap_idx%0d", i));
        end
        waitReady("overlap", bc);

        // Reading the round being written in the same cycle misses
        applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0, 1'b0, '0, "early_load");
        applyStimulus(1'b0, '0, 1'b1, 4'd1, 1'b0, '0, "early_idx1");
        applyStimulus(1'b0, '0, 1'b1, 4'd2, 1'b0, '0, "early_idx2");
        applyStimulus(1'b0, '0, 1'b1, 4'd2, 1'b1, FIPS_RK[2], "early_idx2_later");
        waitReady("early", bc);

        // All-zero key
        applyStimulus(1'b1, '0, 1'b0, 4'd0, 1'b0, '0, "zero_load");
        waitReady("zero", bc);
        checkOutput("zero_busy_cycles", 128'(bc), 128'd10);
        applyStimulus(1'b0, '0, 1'b1, 4'd1, 1'b1, ZERO_RK1, "zero_idx1");
        applyStimulus(1'b0, '0, 1'b1, 4'd10, 1'b1, ZERO_RK10, "zero_idx10");
        applyStimulus(1'b0, '0, 1'b1, 4'd0, 1'b1, '0, "zero_idx0");

        // Reload four cycles into a zero-key expansion
        applyStimulus(1'b1, '0, 1'b0, 4'd0, 1'b0, '0, "reload_first");
        idleCycle();
        idleCycle();
        idleCycle();
        checkOutput("reload_pre_rounds_avail", 128'(rounds_avail), 128'd4);
        applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0, 1'b0, '0, "reload_second");
        checkOutput("reload_rounds_avail", 128'(rounds_avail), 128'd1);
        applyStimulus(1'b0, '0, 1'b1, 4'd3, 1'b0, '0, "reload_stale_idx3");
        waitReady("reload", bc);
        checkOutput("reload_busy_cycles", 128'(bc), 128'd9);
        applyStimulus(1'b0, '0, 1'b1, 4'd10, 1'b1, FIPS_RK[10], "reload_idx10");
        applyStimulus(1'b0, '0, 1'b1, 4'd1, 1'b1, FIPS_RK[1], "reload_idx1");

        // Asynchronous reset mid-expansion, asserted away from any clock edge
        applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0, 1'b0, '0, "areset_load");
        idleCycle();
        idleCycle();
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, '0, 1'b1, 4'd2, 1'b1, FIPS_RK[2], "areset_idx2");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_rd_key", rd_key, '0);
        checkOutput("areset_flags", {123'd0, rd_valid, rd_miss, busy, key_ready, 1'b0}, 128'd0);
        checkOutput("areset_rounds_avail", 128'(rounds_avail), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycle();
        applyStimulus(1'b0, '0, 1'b1, 4'd0, 1'b0, '0, "post_reset_idx0");
        applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0, 1'b0, '0, "post_reset_load");
        applyStimulus(1'b0, '0, 1'b1, 4'd0, 1'b1, FIPS_KEY, "post_reset_idx0_valid");
        idleCycle();
        idleCycle();

        checkOutput("scoreboard_drained", 128'(exp_valid_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
